// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared FSM type and sizing helpers for the Ethernet arbitration mux
package eth_pkg;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_FLUSH = 2'd2,
      ST_GAP   = 2'd3
   } arb_state_t;

   localparam int EMPTY_WIDTH_DEF = 3;

   function automatic int clog2_min1(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/util_rr_prio_pick.sv
// rtl/util_rr_prio_pick.sv - combinational max-level picker with fixed or round-robin tie-break
module util_rr_prio_pick
   import eth_pkg::*;
#(
   parameter int  CHANNEL_QTY     = 3,
   parameter int  ARBIT_LEVEL     = 2,
   parameter int  ARBIT_ALGORITHM = 1,
   localparam int PW              = clog2_min1(CHANNEL_QTY)
) (
   input  logic [CHANNEL_QTY*ARBIT_LEVEL-1:0] req,
   input  logic [PW-1:0]                      ptr,
   output logic [CHANNEL_QTY-1:0]             win,
   output logic                               valid
);
   logic [ARBIT_LEVEL-1:0] max_lvl;
   int                     best_i;
   int                     best_d;
   int                     d;

   always_comb begin
      max_lvl = '0;
      for (int i = 0; i < CHANNEL_QTY; i++) begin
         if (req[i*ARBIT_LEVEL +: ARBIT_LEVEL] > max_lvl)
            max_lvl = req[i*ARBIT_LEVEL +: ARBIT_LEVEL];
      end
   end

   // d is the channel's distance from the search start; smallest distance wins a tie
   always_comb begin
      best_i = 0;
      best_d = CHANNEL_QTY;
      d      = 0;
      for (int i = 0; i < CHANNEL_QTY; i++) begin
         d = (ARBIT_ALGORITHM == 1) ? i - int'(ptr) - 1 : i;
         if (d < 0)
            d = d + CHANNEL_QTY;
         if (max_lvl != '0 && req[i*ARBIT_LEVEL +: ARBIT_LEVEL] == max_lvl && d < best_d) begin
            best_d = d;
            best_i = i;
         end
      end
      valid = (max_lvl != '0);
      win   = valid ? (CHANNEL_QTY'(1) << best_i) : '0;
   end
endmodule

// File: rtl/eth_arbit_mux_n.sv
// rtl/eth_arbit_mux_n.sv - N-channel prioritised packet arbiter and output mux with grant watchdog
module eth_arbit_mux_n
   import eth_pkg::*;
#(
   parameter int  DATA_WIDTH      = 64,
   parameter int  EMPTY_WIDTH     = EMPTY_WIDTH_DEF,
   parameter int  CHANNEL_QTY     = 3,
   parameter int  ARBIT_LEVEL     = 2,
   parameter int  ARBIT_ALGORITHM = 1,
   parameter int  MUX_SW_DELAY    = 2,
   parameter int  TIMEOUT_CYCLES  = 4096,
   parameter int  INDX_WIDTH      = 10,
   localparam int CW              = clog2_min1(CHANNEL_QTY)
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [CHANNEL_QTY*ARBIT_LEVEL-1:0] arbit_request,
   input  logic [CHANNEL_QTY-1:0]             arbit_eop,
   output logic [CHANNEL_QTY-1:0]             arbit_grant,
   output logic [INDX_WIDTH-1:0]              arbit_index,
   input  logic [CHANNEL_QTY-1:0]             din_sop,
   input  logic [CHANNEL_QTY-1:0]             din_eop,
   input  logic [CHANNEL_QTY-1:0]             din_valid,
   input  logic [CHANNEL_QTY*DATA_WIDTH-1:0]  din_data,
   input  logic [CHANNEL_QTY*EMPTY_WIDTH-1:0] din_empty,
   output logic [CHANNEL_QTY-1:0]             din_ready,
   input  logic                               dout_ready,
   output logic                               dout_sop,
   output logic                               dout_eop,
   output logic                               dout_valid,
   output logic [DATA_WIDTH-1:0]              dout_data,
   output logic [EMPTY_WIDTH-1:0]             dout_empty,
   output logic                               dout_error,
   output logic [CW-1:0]                      dout_channel,
   output logic [15:0]                        timeout_cnt
);
   arb_state_t              state, state_nxt;
   logic [CHANNEL_QTY-1:0]  grant_nxt, pick_win;
   logic                    pick_valid;
   logic [CW-1:0]           gidx, gidx_nxt, ptr, ptr_nxt, win_idx;
   logic [INDX_WIDTH-1:0]   index_nxt;
   logic [31:0]             wd_cnt, wd_nxt, gap_cnt, gap_nxt;
   logic [15:0]             timeout_nxt;
   logic                    pkt_open, open_nxt;
   logic                    ov_nxt, osop_nxt, oeop_nxt, oerr_nxt;
   logic [DATA_WIDTH-1:0]   odata_nxt;
   logic [EMPTY_WIDTH-1:0]  oempty_nxt;
   logic [CW-1:0]           och_nxt;
   logic                    out_free, accept, wd_fire;

   util_rr_prio_pick #(
      .CHANNEL_QTY     (CHANNEL_QTY),
      .ARBIT_LEVEL     (ARBIT_LEVEL),
      .ARBIT_ALGORITHM (ARBIT_ALGORITHM)
   ) u_pick (
      .req   (arbit_request),
      .ptr   (ptr),
      .win   (pick_win),
      .valid (pick_valid)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < CHANNEL_QTY; i++) begin
         if (pick_win[i])
            win_idx = CW'(i);
      end
   end

   assign out_free  = ~dout_valid | dout_ready;
   assign accept    = (state == ST_GRANT) && din_valid[gidx] && out_free;
   assign wd_fire   = (TIMEOUT_CYCLES != 0) && (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
   assign din_ready = (state == ST_GRANT && out_free) ? arbit_grant : '0;

   always_comb begin
      state_nxt   = state;
      grant_nxt   = arbit_grant;
      gidx_nxt    = gidx;
      ptr_nxt     = ptr;
      index_nxt   = arbit_index;
      wd_nxt      = wd_cnt;
      gap_nxt     = gap_cnt;
      timeout_nxt = timeout_cnt;
      open_nxt    = pkt_open;
      ov_nxt      = dout_valid & ~dout_ready;
      osop_nxt    = dout_sop;
      oeop_nxt    = dout_eop;
      oerr_nxt    = dout_error;
      odata_nxt   = dout_data;
      oempty_nxt  = dout_empty;
      och_nxt     = dout_channel;
      if (accept) begin
         ov_nxt     = 1'b1;
         osop_nxt   = din_sop[gidx];
         oeop_nxt   = din_eop[gidx];
         oerr_nxt   = 1'b0;
         odata_nxt  = din_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
         oempty_nxt = din_empty[int'(gidx)*EMPTY_WIDTH +: EMPTY_WIDTH];
         och_nxt    = gidx;
         if (din_eop[gidx])
            open_nxt = 1'b0;
         else if (din_sop[gidx])
            open_nxt = 1'b1;
      end
      case (state)
         // a new grant waits for the previous channel's last beat to leave the output register
         ST_IDLE: begin
            if (pick_valid && !dout_valid) begin
               grant_nxt = pick_win;
               gidx_nxt  = win_idx;
               ptr_nxt   = win_idx;
               index_nxt = arbit_index + 1'b1;
               wd_nxt    = '0;
               state_nxt = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (arbit_eop[gidx]) begin
               grant_nxt = '0;
               gap_nxt   = '0;
               state_nxt = ST_GAP;
            end else if (wd_fire) begin
               grant_nxt = '0;
               gap_nxt   = '0;
               if (timeout_cnt != 16'hFFFF)
                  timeout_nxt = timeout_cnt + 16'd1;
               state_nxt = open_nxt ? ST_FLUSH : ST_GAP;
            end else begin
               wd_nxt = wd_cnt + 32'd1;
            end
         end
         ST_FLUSH: begin
            if (out_free) begin
               ov_nxt     = 1'b1;
               osop_nxt   = 1'b0;
               oeop_nxt   = 1'b1;
               oerr_nxt   = 1'b1;
               odata_nxt  = '0;
               oempty_nxt = '0;
               och_nxt    = gidx;
               open_nxt   = 1'b0;
               gap_nxt    = '0;
               state_nxt  = ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_cnt + 32'd1 >= 32'(MUX_SW_DELAY))
               state_nxt = ST_IDLE;
            else
               gap_nxt = gap_cnt + 32'd1;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         arbit_grant  <= '0;
         gidx         <= '0;
         ptr          <= CW'(CHANNEL_QTY - 1);
         arbit_index  <= '0;
         wd_cnt       <= '0;
         gap_cnt      <= '0;
         timeout_cnt  <= '0;
         pkt_open     <= 1'b0;
         dout_valid   <= 1'b0;
         dout_sop     <= 1'b0;
         dout_eop     <= 1'b0;
         dout_error   <= 1'b0;
         dout_data    <= '0;
         dout_empty   <= '0;
         dout_channel <= '0;
      end else begin
         state        <= state_nxt;
         arbit_grant  <= grant_nxt;
         gidx         <= gidx_nxt;
         ptr          <= ptr_nxt;
         arbit_index  <= index_nxt;
         wd_cnt       <= wd_nxt;
         gap_cnt      <= gap_nxt;
         timeout_cnt  <= timeout_nxt;
         pkt_open     <= open_nxt;
         dout_valid   <= ov_nxt;
         dout_sop     <= osop_nxt;
         dout_eop     <= oeop_nxt;
         dout_error   <= oerr_nxt;
         dout_data    <= odata_nxt;
         dout_empty   <= oempty_nxt;
         dout_channel <= och_nxt;
      end
   end
endmodule

// File: doc/eth_arbit_mux_n.md
Name: eth_arbit_mux_n

Overview:
- Parametrised N-channel Avalon-ST packet arbiter/multiplexer; successor to the fixed three-channel arbitration mux used in the PUSCH/timing Ethernet aggregation path.
- Merges packets from CHANNEL_QTY sources (timing packetiser plus any number of antenna packetisers) onto one Ethernet-bound stream.
- Adds multi-level priority with round-robin tie-break, downstream backpressure (dout_ready), and a per-grant watchdog that force-terminates stalled packets with an error flag.

Parameters:
- DATA_WIDTH, 64: beat width in bits.
- EMPTY_WIDTH, 3: width of the empty field; must equal log2(DATA_WIDTH/8).
- CHANNEL_QTY, 3: number of source channels, 2..16.
- ARBIT_LEVEL, 2: width of each channel's priority code. 0 means no request; a higher value means a higher priority.
- ARBIT_ALGORITHM, 1: tie-break among channels at the same level. 0 = fixed (lowest index wins); 1 = round-robin.
- MUX_SW_DELAY, 2: number of idle gap cycles after each grant is released.
- TIMEOUT_CYCLES, 4096: maximum number of cycles a grant may be held. 0 disables the watchdog.
- INDX_WIDTH, 10: width of the granted-packet counter.

Ports:
- clk, in, 1: the single clock.
- rst, in, 1: asynchronous, active-high reset.
- arbit_request, in, CHANNEL_QTY*ARBIT_LEVEL: per-channel priority code; channel i occupies slice [i*ARBIT_LEVEL +: ARBIT_LEVEL].
- arbit_eop, in, CHANNEL_QTY: pulse from the source indicating its last beat has been accepted.
- arbit_grant, out, CHANNEL_QTY: one-hot grant.
- arbit_index, out, INDX_WIDTH: running count of grants issued.
- din_sop, din_eop, din_valid, in, CHANNEL_QTY each: per-channel packet framing.
- din_data, in, CHANNEL_QTY*DATA_WIDTH: per-channel data.
- din_empty, in, CHANNEL_QTY*EMPTY_WIDTH: per-channel empty field.
- din_ready, out, CHANNEL_QTY: per-channel ready.
- dout_ready, in, 1: downstream ready.
- dout_sop, dout_eop, dout_valid, out, 1 each: output framing.
- dout_data, out, DATA_WIDTH: output data.
- dout_empty, out, EMPTY_WIDTH: output empty field.
- dout_error, out, 1: marks a watchdog-terminated beat.
- dout_channel, out, $clog2(CHANNEL_QTY): source channel of the current beat.
- timeout_cnt, out, 16: watchdog event counter, saturating.

Behaviour:
- Reset: every output is 0, including arbit_grant, arbit_index, dout_*, din_ready and timeout_cnt. The FSM enters IDLE and the round-robin pointer resets to CHANNEL_QTY-1, so channel 0 is searched first.
- FSM states are IDLE, GRANT, FLUSH and GAP.
- IDLE:
  - Find the maximum request level among all channels. If it is non-zero, pick the winner at that level.
  - With ARBIT_ALGORITHM=1, search from ptr+1 modulo CHANNEL_QTY. With ARBIT_ALGORITHM=0, the lowest index wins.
  - Register the winner. arbit_grant[winner] goes high on the next cycle; ptr is set to winner; arbit_index increments, wrapping at 2^INDX_WIDTH.
  - Transition to GRANT.
  - Requests are sampled only in IDLE. Changes to a request while a grant is held have no effect.
- GRANT:
  - Only the granted channel's din_valid is used. Beats from other channels are ignored, and their din_ready is 0.
  - The output stage is a single register. din_ready[g] = ~dout_valid | dout_ready.
  - A beat is accepted when din_valid[g] & din_ready[g]. It appears on dout_* one cycle later, together with dout_channel = g.
  - dout_valid holds until dout_ready is high. Latency from input to output is 1 cycle when there is no backpressure.
  - arbit_eop[g] drops the grant on the next cycle and the FSM moves to GAP. This holds even if arbit_eop arrives on the same cycle as the last accepted beat.
- Watchdog:
  - A cycle counter is cleared on every grant.
  - If it reaches TIMEOUT_CYCLES while in GRANT, the grant drops immediately and timeout_cnt increments.
  - If a packet is open on the output (an sop has been emitted without an eop), the FSM goes to FLUSH. Otherwise it goes to GAP.
- FLUSH: emit one beat with data = 0, empty = 0, eop = 1 and error = 1, honouring dout_ready, then go to GAP.
- GAP: the FSM stays idle for MUX_SW_DELAY cycles, then returns to IDLE. With MUX_SW_DELAY=0 it passes straight to IDLE after one cycle.
- A pending output beat is never lost. Before a grant change, the output register drains under dout_ready.
- Arbitrary stalls on dout_ready are permitted. The watchdog counts stall cycles too.
- Asynchronous reset in mid-packet clears everything immediately. A downstream truncated packet is acceptable.

Decomposition:
- Shared package eth_pkg holds:
  - typedef arb_state_t, the FSM state enumeration.
  - localparam function clog2_min1, which returns at least 1.
  - The constant for the default EMPTY_WIDTH.
- One sub-module, util_rr_prio_pick: a combinational max-level and round-robin picker, with inputs req levels and ptr and outputs a one-hot winner plus a valid flag.

Test Plan:
- Priority: ch0 at level 1 and ch2 at level 3, asserted together → grant is 3'b100 first; after ch2's arbit_eop and 2 gap cycles, grant is 3'b001; arbit_index reads 1 then 2.
- Round-robin: all 3 channels held continuously at level 1 → grant order is 0, 1, 2, 0; there are exactly MUX_SW_DELAY=2 idle cycles between grants.
- Backpressure: ch1 sends 4 beats while dout_ready toggles 1,0,0,1,… → output carries 4 beats, in order, with data intact; sop appears only on beat 0 and eop only on beat 3; dout_channel=1 throughout.
- Watchdog: TIMEOUT_CYCLES=16; ch0 sends sop plus 2 beats, then stalls → at cycle 16 the grant drops, one beat with eop=1, error=1 and data=0 is emitted, and timeout_cnt=1.
- Ignored traffic: ch2 drives din_valid while ch0 holds the grant → no ch2 beats appear on the output, and din_ready[2] stays 0.
- Reset: rst is asserted mid-packet → all outputs are 0 asynchronously; after release, a new request is granted normally.
